// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side word buffer sitting directly behind the UART receiver.
// Each rising edge of the receiver's `write` strobe pushes one word, however long
// the strobe stays high. The consumer pops words with `rd`. The block reports the
// fill level, full, almost-full and a sticky overflow flag.
// Optional build macro UART_RX_FIFO_FWFT_EN selects first-word-fall-through reads:
// `q` then shows the head word and `qv` = ~empty. Without the macro a pop returns
// the word on `q` one cycle later, with a one-cycle `qv` pulse.
module uart_rx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AFULL = 12
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     write,
   input  logic [WIDTH-1:0]         Data,
   input  logic                     rd,
   input  logic                     clr_ovf,
   output logic [WIDTH-1:0]         q,
   output logic                     qv,
   output logic                     empty,
   output logic                     full,
   output logic                     afull,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   localparam logic [LW-1:0] LVL_ZERO  = LW'(0);
   localparam logic [LW-1:0] LVL_ONE   = LW'(1);
   localparam logic [LW-1:0] LVL_DEPTH = LW'(DEPTH);
   localparam logic [LW-1:0] LVL_AFULL = LW'(AFULL);
   localparam logic [AW-1:0] PTR_ZERO  = AW'(0);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);

   // storage and state registers
   logic [WIDTH-1:0] mem_r [DEPTH];
   logic             write_d_r;
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [LW-1:0]    level_r;
   logic             empty_r;
   logic             full_r;
   logic             afull_r;
   logic             overflow_r;
   logic [WIDTH-1:0] q_r;
   logic             qv_r;

   // combinational next-state values
   logic             push_s;
   logic             pop_s;
   logic             accept_s;
   logic             drop_s;
   logic [LW-1:0]    level_nxt_s;
   logic [AW-1:0]    wr_ptr_nxt_s;
   logic [AW-1:0]    rd_ptr_nxt_s;
   logic             overflow_nxt_s;
   logic [WIDTH-1:0] q_nxt_s;
   logic             qv_nxt_s;

   // Detect the write rising edge, qualify pops, and decide push accept or drop.
   // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
   always_comb begin
      push_s   = write & ~write_d_r;
      pop_s    = rd & ~empty_r;
      accept_s = push_s & (~full_r | pop_s);
      drop_s   = push_s & full_r & ~pop_s;
   end

   // Compute the next level, the next pointers and the sticky overflow value.
   // A new drop wins over a clear arriving in the same cycle.
   always_comb begin
      level_nxt_s = level_r;
      case ({accept_s, pop_s})
         2'b10:   level_nxt_s = level_r + LVL_ONE;
         2'b01:   level_nxt_s = level_r - LVL_ONE;
         default: level_nxt_s = level_r;
      endcase

      if (accept_s) begin
         wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
      end else begin
         wr_ptr_nxt_s = wr_ptr_r;
      end

      if (pop_s) begin
         rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end

      if (drop_s) begin
         overflow_nxt_s = 1'b1;
      end else if (clr_ovf) begin
         overflow_nxt_s = 1'b0;
      end else begin
         overflow_nxt_s = overflow_r;
      end
   end

`ifdef UART_RX_FIFO_FWFT_EN
   // Compute the head word that will be visible after this edge.
   // If the only word left after a pop is the one being written now, take it
   // straight from Data, because the memory does not hold it yet.
   always_comb begin
      q_nxt_s  = q_r;
      qv_nxt_s = (level_nxt_s != LVL_ZERO);
      if (level_nxt_s != LVL_ZERO) begin
         if (accept_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            q_nxt_s = Data;
         end else begin
            q_nxt_s = mem_r[rd_ptr_nxt_s];
         end
      end else begin
         q_nxt_s = q_r;
      end
   end
`else
   // Registered read: a pop loads the head word into q for one qv cycle.
   // Without a pop, q holds its last value.
   always_comb begin
      q_nxt_s  = q_r;
      qv_nxt_s = pop_s;
      if (pop_s) begin
         q_nxt_s = mem_r[rd_ptr_r];
      end else begin
         q_nxt_s = q_r;
      end
   end
`endif

   // Write an accepted word into the circular storage.
   always_ff @(posedge clk) begin
      if (!reset && accept_s) begin
         mem_r[wr_ptr_r] <= Data;
      end
   end

   // Update pointers, level, flags and read outputs on the same edge.
   // write_d resets high so that a write held across reset is not taken as a push.
   always_ff @(posedge clk) begin
      if (reset) begin
         write_d_r  <= 1'b1;
         wr_ptr_r   <= PTR_ZERO;
         rd_ptr_r   <= PTR_ZERO;
         level_r    <= LVL_ZERO;
         empty_r    <= 1'b1;
         full_r     <= 1'b0;
         afull_r    <= 1'b0;
         overflow_r <= 1'b0;
         q_r        <= {WIDTH{1'b0}};
         qv_r       <= 1'b0;
      end else begin
         write_d_r  <= write;
         wr_ptr_r   <= wr_ptr_nxt_s;
         rd_ptr_r   <= rd_ptr_nxt_s;
         level_r    <= level_nxt_s;
         empty_r    <= (level_nxt_s == LVL_ZERO);
         full_r     <= (level_nxt_s == LVL_DEPTH);
         afull_r    <= (level_nxt_s >= LVL_AFULL);
         overflow_r <= overflow_nxt_s;
         q_r        <= q_nxt_s;
         qv_r       <= qv_nxt_s;
      end
   end

   assign q        = q_r;
   assign qv       = qv_r;
   assign empty    = empty_r;
   assign full     = full_r;
   assign afull    = afull_r;
   assign level    = level_r;
   assign overflow = overflow_r;

endmodule
